ram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port embedded data RAM between the CPU load/store port (master 0) and the DMA/debug-loader port (master 1). It owns the RAM's shared bus (write enable, address, bidirectional data), serializes accesses with a round-robin grant plus an optional bounded bus lock, and returns per-master read data and a one-cycle acknowledge. It sits between the masters and the RAM in the embedded SoC memory map.

---
 rtl/ram_arbiter_if.sv | 15 +
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// One master's request/response bundle toward the RAM arbiter.
// The arbiter uses the slave view; requesters use the master view.
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, lock, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, lock, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-master arbiter for the single-port data RAM, with a bounded lock for bursts.
// Ack arrives 2 cycles after the request edge; the losing master holds req and waits, nothing is dropped.
module ram_arbiter #(
  parameter int ADDR_MAX = 1023,
  parameter int LOCK_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave m0,
  ram_arbiter_if.slave m1,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  inout  wire  [31:0]  mem_data
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t          state;
  logic            owner;
  logic            rr;
  logic [LCW-1:0]  lock_cnt;
  logic            acc_we;
  logic            acc_err;
  logic [31:0]     wdata_q;
  logic [1:0]      ack_q;
  logic [1:0]      err_q;
  logic [31:0]     rdata_q [2];

  logic [1:0]      req;
  logic [1:0]      we;
  logic [1:0]      lock;
  logic [31:0]     addr  [2];
  logic [31:0]     wdata [2];

  logic            winner;
  logic            sel;
  logic            sel_ok;
  logic            burst_more;
  logic            load;

  assign req      = {m1.req, m0.req};
  assign we       = {m1.we, m0.we};
  assign lock     = {m1.lock, m0.lock};
  assign addr[0]  = m0.addr;
  assign addr[1]  = m1.addr;
  assign wdata[0] = m0.wdata;
  assign wdata[1] = m1.wdata;

  assign m0.ack   = ack_q[0];
  assign m1.ack   = ack_q[1];
  assign m0.err   = err_q[0];
  assign m1.err   = err_q[1];
  assign m0.rdata = rdata_q[0];
  assign m1.rdata = rdata_q[1];

  // Only an in-range write access ever drives the shared data bus.
  assign mem_data = mem_we ? wdata_q : 'z;

  always_comb begin
    winner     = (req[0] & req[1]) ? rr : req[1];
    sel        = (state == IDLE) ? winner : owner;
    sel_ok     = (addr[sel] <= 32'(ADDR_MAX));
    burst_more = lock[owner] & req[owner] & (lock_cnt < LCW'(LOCK_MAX - 1));
    load       = ((state == IDLE) & (|req)) | ((state == ACK) & burst_more);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr         <= 1'b0;
      lock_cnt   <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Out-of-range reads return zero rather than whatever the RAM aliases to.
          if (!acc_we) rdata_q[owner] <= acc_err ? '0 : mem_data;
          ack_q[owner] <= 1'b1;
          err_q[owner] <= acc_err;
          rr           <= ~owner;
          state        <= ACK;
        end
        ACK: begin
          ack_q <= '0;
          err_q <= '0;
          if (burst_more) begin
            lock_cnt <= lock_cnt + LCW'(1);
            state    <= BUSY;
          end else begin
            lock_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus-side access registers, loaded on every grant and cleared after the BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      acc_we   <= 1'b0;
      acc_err  <= 1'b0;
      wdata_q  <= '0;
    end else if (load) begin
      mem_we   <= we[sel] & sel_ok;
      mem_addr <= addr[sel];
      acc_we   <= we[sel];
      acc_err  <= ~sel_ok;
      wdata_q  <= wdata[sel];
    end else if (state == BUSY) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM on the shared bus.
// The RAM drives the bus whenever mem_we is low, so any stray arbiter drive corrupts what it sees.
module tb_ram_arbiter;
  logic        clk;
  logic        rst;
  logic        ram_init;
  logic        mem_we;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic [31:0] ram [256];
  int          total;
  int          bad;

  ram_arbiter_if m0_if ();
  ram_arbiter_if m1_if ();

  ram_arbiter #(.ADDR_MAX(1023), .LOCK_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = mem_we ? 32'bz : ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_we) begin
      ram[mem_addr[9:2]] <= mem_data;
    end
  end

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    m0_if.req = r; m0_if.we = w; m0_if.lock = l; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    m1_if.req = r; m1_if.we = w; m1_if.lock = l; m1_if.addr = a; m1_if.wdata = d;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    ram_init = 1'b1;
    drv0(0, 0, 0, 32'h0, 32'h0);
    drv1(0, 0, 0, 32'h0, 32'h0);
    nc();
    ram_init = 1'b0;
    nc();

    // reset state
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_data_released", mem_data, 32'hA500_0000);
    chk1("rst_m0_ack", m0_if.ack, 1'b0);
    chk1("rst_m1_ack", m1_if.ack, 1'b0);
    chk32("rst_m0_rdata", m0_if.rdata, 32'h0);
    chk32("rst_m1_rdata", m1_if.rdata, 32'h0);
    rst = 1'b1;

    // m0 write then read of 0x10
    drv0(1, 1, 0, 32'h10, 32'hDEAD_BEEF);
    nc();
    chk1("t1_busy_we", mem_we, 1'b1);
    chk32("t1_busy_addr", mem_addr, 32'h10);
    chk32("t1_busy_data", mem_data, 32'hDEAD_BEEF);
    chk1("t1_busy_noack", m0_if.ack, 1'b0);
    nc();
    chk1("t1_wr_ack", m0_if.ack, 1'b1);
    chk1("t1_wr_err", m0_if.err, 1'b0);
    chk1("t1_ack_we", mem_we, 1'b0);
    drv0(1, 0, 0, 32'h10, 32'h0);
    nc();
    chk32("t1_idle_addr", mem_addr, 32'h0);
    chk1("t1_idle_ack", m0_if.ack, 1'b0);
    nc();
    chk32("t1_rd_addr", mem_addr, 32'h10);
    chk32("t1_rd_bus", mem_data, 32'hDEAD_BEEF);
    nc();
    chk1("t1_rd_ack", m0_if.ack, 1'b1);
    chk32("t1_rd_data", m0_if.rdata, 32'hDEAD_BEEF);
    chk1("t1_rd_err", m0_if.err, 1'b0);
    drv0(0, 0, 0, 32'h0, 32'h0);

    // simultaneous reads from reset: m0 first, then m1, twice
    rst = 1'b0;
    nc();
    rst = 1'b1;
    drv0(1, 0, 0, 32'h10, 32'h0);
    drv1(1, 0, 0, 32'h14, 32'h0);
    nc();
    chk32("t2_first_grant", mem_addr, 32'h10);
    nc();
    chk1("t2_m0_ack", m0_if.ack, 1'b1);
    chk1("t2_m1_wait", m1_if.ack, 1'b0);
    chk32("t2_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    drv0(0, 0, 0, 32'h0, 32'h0);
    nc();
    nc();
    chk32("t2_second_grant", mem_addr, 32'h14);
    nc();
    chk1("t2_m1_ack", m1_if.ack, 1'b1);
    chk32("t2_m1_rdata", m1_if.rdata, 32'hA500_0005);
    drv0(1, 0, 0, 32'h18, 32'h0);
    drv1(1, 0, 0, 32'h1C, 32'h0);
    nc();
    nc();
    chk32("t2_rep_first_grant", mem_addr, 32'h18);
    nc();
    chk1("t2_rep_m0_ack", m0_if.ack, 1'b1);
    chk1("t2_rep_m1_wait", m1_if.ack, 1'b0);
    chk32("t2_rep_m0_rdata", m0_if.rdata, 32'hA500_0006);
    drv0(0, 0, 0, 32'h0, 32'h0);
    nc();
    nc();
    chk32("t2_rep_second_grant", mem_addr, 32'h1C);
    nc();
    chk1("t2_rep_m1_ack", m1_if.ack, 1'b1);
    chk32("t2_rep_m1_rdata", m1_if.rdata, 32'hA500_0007);
    drv1(0, 0, 0, 32'h0, 32'h0);
    nc();

    // m1 locked write burst capped at 4, m0 waiting
    drv1(1, 1, 1, 32'h40, 32'h1111_0000);
    for (int k = 1; k <= 8; k++) begin
      nc();
      if (k == 1) drv0(1, 0, 0, 32'h10, 32'h0);
      chk1("t3_m1_ack", m1_if.ack, (k % 2) == 0);
      chk1("t3_m0_wait", m0_if.ack, 1'b0);
      if ((k % 2) == 1) begin
        chk32("t3_burst_addr", mem_addr, 32'h40 + 32'(4 * ((k - 1) / 2)));
      end else begin
        drv1(1, 1, 1, 32'h40 + 32'(4 * (k / 2)), 32'h1111_0000 + 32'(k / 2));
      end
    end
    nc();
    chk1("t3_forced_idle_we", mem_we, 1'b0);
    chk32("t3_forced_idle_addr", mem_addr, 32'h0);
    nc();
    chk32("t3_m0_grant_addr", mem_addr, 32'h10);
    nc();
    chk1("t3_m0_ack", m0_if.ack, 1'b1);
    chk1("t3_m1_no_ack", m1_if.ack, 1'b0);
    chk32("t3_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    drv0(0, 0, 0, 32'h0, 32'h0);
    nc();
    nc();
    chk32("t3_m1_resume_addr", mem_addr, 32'h50);
    chk1("t3_m1_resume_we", mem_we, 1'b1);
    chk32("t3_m1_resume_data", mem_data, 32'h1111_0004);
    nc();
    chk1("t3_m1_resume_ack", m1_if.ack, 1'b1);
    drv1(0, 0, 0, 32'h0, 32'h0);
    nc();

    // out-of-range write and read at 1024
    drv0(1, 1, 0, 32'h400, 32'hCAFE_F00D);
    nc();
    chk1("t4_wr_busy_we", mem_we, 1'b0);
    chk32("t4_wr_busy_addr", mem_addr, 32'h400);
    chk32("t4_wr_bus_released", mem_data, 32'hA500_0000);
    nc();
    chk1("t4_wr_ack", m0_if.ack, 1'b1);
    chk1("t4_wr_err", m0_if.err, 1'b1);
    chk1("t4_wr_ack_we", mem_we, 1'b0);
    drv0(1, 0, 0, 32'h400, 32'h0);
    nc();
    chk1("t4_idle_we", mem_we, 1'b0);
    nc();
    chk1("t4_rd_busy_we", mem_we, 1'b0);
    chk32("t4_rd_bus", mem_data, 32'hA500_0000);
    nc();
    chk1("t4_rd_ack", m0_if.ack, 1'b1);
    chk1("t4_rd_err", m0_if.err, 1'b1);
    chk32("t4_rd_zero", m0_if.rdata, 32'h0);
    drv0(0, 0, 0, 32'h0, 32'h0);
    nc();

    // reset during BUSY of an m1 write to 0x20
    drv1(1, 1, 0, 32'h20, 32'h55AA_55AA);
    nc();
    chk1("t5_busy_we", mem_we, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t5_rst_we", mem_we, 1'b0);
    chk32("t5_rst_addr", mem_addr, 32'h0);
    chk32("t5_rst_bus", mem_data, 32'hA500_0000);
    drv1(0, 0, 0, 32'h0, 32'h0);
    nc();
    chk1("t5_no_ack", m1_if.ack, 1'b0);
    chk1("t5_no_err", m0_if.err, 1'b0);
    chk32("t5_m0_rdata", m0_if.rdata, 32'h0);
    chk32("t5_m1_rdata", m1_if.rdata, 32'h0);
    rst = 1'b1;
    drv1(1, 0, 0, 32'h20, 32'h0);
    nc();
    chk32("t5_rd_addr", mem_addr, 32'h20);
    chk32("t5_rd_bus", mem_data, 32'hA500_0008);
    nc();
    chk1("t5_rd_ack", m1_if.ack, 1'b1);
    chk32("t5_old_contents", m1_if.rdata, 32'hA500_0008);
    drv1(0, 0, 0, 32'h0, 32'h0);
    nc();

    // m1 read with stale all-ones wdata must not reach the bus
    drv1(1, 0, 0, 32'h24, 32'hFFFF_FFFF);
    nc();
    chk1("t6_busy_we", mem_we, 1'b0);
    chk32("t6_bus_undriven", mem_data, 32'hA500_0009);
    nc();
    chk1("t6_ack", m1_if.ack, 1'b1);
    chk32("t6_m1_rdata", m1_if.rdata, 32'hA500_0009);
    chk32("t6_m0_rdata_held", m0_if.rdata, 32'h0);
    drv1(0, 0, 0, 32'h0, 32'h0);
    nc();
    chk1("t6_ack_done", m1_if.ack, 1'b0);
    chk32("t6_idle_bus", mem_data, 32'hA500_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
